// File: rtl/cdc_handshake_tx.sv
// Purpose : source half of a 4-phase req/ack CDC; holds one Width-bit word on data_o while req_o is raised.
// Latency : req_o rises 1 cycle after accept; ideal round trip is 2*SyncStages+2 clk_i cycles plus far-end delay.
// Backpress: ready_o low from accept until the synchronised ack has fallen again; valid_i is ignored meanwhile.
//
// Ports
//   clk_i    in   1      source-domain clock
//   rst_ni   in   1      asynchronous, active-low reset
//   valid_i  in   1      upstream word valid
//   ready_o  out  1      word can be accepted this cycle
//   data_i   in   Width  upstream word
//   req_o    out  1      request to far domain (registered)
//   data_o   out  Width  word held for the far domain (registered)
//   ack_i    in   1      acknowledge from far domain (asynchronous)
//   busy_o   out  1      handshake in progress
//   err_o    out  1      sticky watchdog error
//
// Optional feature: define CDC_TX_TIMEOUT_EN to build the watchdog counter
// that drives err_o. Without it err_o is tied low and TimeoutCycles is unused.

module cdc_handshake_tx #(
    parameter int unsigned Width         = 32,
    parameter int unsigned SyncStages    = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             req_o,
    output logic [Width-1:0] data_o,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             err_o
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (Width < 1) begin : g_chk_width
        $fatal(1, "cdc_handshake_tx: Width must be >= 1");
    end

    // A single flop would pass metastability straight into the FSM.
    if (SyncStages < 2) begin : g_chk_sync
        $fatal(1, "cdc_handshake_tx: SyncStages must be >= 2");
    end

    if (TimeoutCycles < 2) begin : g_chk_timeout
`ifdef CDC_TX_TIMEOUT_EN
        $fatal(1, "cdc_handshake_tx: TimeoutCycles must be >= 2");
`endif
    end

    // ------------------------------------------------------------------
    // Types and state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e state_q;
    state_e state_d;

    logic             req_q;
    logic             req_d;
    logic [Width-1:0] data_q;
    logic             load;

    // ------------------------------------------------------------------
    // ack_i synchroniser
    // ------------------------------------------------------------------
    // Plain shift chain; the last stage is the only one the FSM may look at.
    // Resetting it to 0 means a far end that is still acking after reset
    // becomes visible SyncStages cycles after release, not immediately.
    logic [SyncStages-1:0] ack_sync_q;
    logic                  ack_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SyncStages-2:0], ack_i};
        end
    end

    assign ack_s = ack_sync_q[SyncStages-1];

    // ------------------------------------------------------------------
    // Handshake FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM: next state
    // ------------------------------------------------------------------
    // IDLE -> REQ  : word accepted, raise req
    // REQ  -> DROP : far end has seen the word (ack_s high), drop req
    // DROP -> IDLE : far end has returned ack to zero
    // An ack that glitches low while in REQ simply keeps us waiting in REQ.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
                if (valid_i && ready_o) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_d = ST_DROP;
                    req_d   = 1'b0;
                end
            end
            ST_DROP: begin
                req_d = 1'b0;
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Held data word
    // ------------------------------------------------------------------
    // Loaded only on accept, so it is frozen for the whole REQ and DROP
    // phases and keeps its last value through IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // ready_o also waits for ack_s low so a stale far-end ack (after reset
    // or a reset mid-handshake) can never be mistaken for the next word's ack.
    assign ready_o = (state_q == ST_IDLE) && !ack_s;
    assign busy_o  = (state_q != ST_IDLE);
    assign req_o   = req_q;
    assign data_o  = data_q;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef CDC_TX_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] wd_cnt_q;
    logic            err_q;

    // Counts cycles spent in REQ or DROP since the last accept and
    // saturates at TimeoutCycles. The error flag is raised on the same edge
    // the count reaches the limit; the handshake itself keeps going.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (load) begin
                wd_cnt_q <= '0;
            end else if (busy_o && (wd_cnt_q != CntMax)) begin
                wd_cnt_q <= wd_cnt_q + CntOne;
            end

            if (busy_o && (wd_cnt_q == CntMax - CntOne)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Protocol invariants
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    // The far end samples data_o while it sees req high, and the word must
    // also stay put during the return-to-zero phase.
    a_data_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (req_o || (state_q == ST_DROP)) |=> $stable(data_o)
    );

    // req is high exactly while in REQ.
    a_req_state: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        req_o == (state_q == ST_REQ)
    );

    // Never offer to accept while a handshake is open.
    a_ready_idle: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ready_o |-> !busy_o
    );
`endif

endmodule
